// File: rtl/iomem_uart_bridge.sv
// iomem_uart_bridge: byte-stream command parser driving a single-word iomem
// bus initiator, with a byte-stream response path.
//
// Commands: 'W' (0x57) + 4 address bytes + 4 data bytes, answered by 0x06.
//           'R' (0x52) + 4 address bytes, answered by 4 read-data bytes.
// Multi-byte fields are big-endian; unknown opcodes are silently dropped.
//
// Optional build macro IOMEM_TIMEOUT_EN: abort a bus cycle after
// TIMEOUT_CYCLES cycles without iomem_ready and answer 0x15 (NAK).
//
// Handshake semantics (all three interfaces): a transfer happens on a rising
// edge where valid && ready are both high; a source never withdraws valid or
// changes its payload until that edge, and ready may depend on state only.
module iomem_uart_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  output logic        busy,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [7:0]  OP_WRITE = 8'h57;
  localparam logic [7:0]  OP_READ  = 8'h52;
  localparam logic [7:0]  RSP_ACK  = 8'h06;
  localparam logic [7:0]  RSP_NAK  = 8'h15;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_cnt;
  logic        r_write;
  logic        r_nak;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [23:0] r_rdata;
  logic        r_iomem_valid;
  logic [3:0]  r_iomem_wstrb;
  logic        r_out_valid;
  logic [7:0]  r_out_data;
  logic        r_busy;

  logic        w_in_fire;
  logic        w_is_op;
  logic        w_bus_done;
  logic        w_out_fire;
  logic        w_resp_last;
  logic        w_timeout;
  logic [7:0]  w_next_byte;

  assign in_ready    = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA);
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign iomem_valid = r_iomem_valid;
  assign iomem_wstrb = r_iomem_wstrb;
  assign iomem_addr  = r_addr;
  assign iomem_wdata = r_wdata;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

  assign w_in_fire   = in_valid && in_ready;
  assign w_is_op     = (in_data == OP_WRITE) || (in_data == OP_READ);
  // A ready pulse only counts while a request is actually outstanding.
  assign w_bus_done  = (r_state == S_BUS) && r_iomem_valid && iomem_ready;
  assign w_out_fire  = r_out_valid && out_ready;
  assign w_resp_last = r_nak || r_write || (r_cnt == 2'd3);

`ifdef IOMEM_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;

  // Cycle counter for the current bus request; zero whenever outside BUS.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               r_tmo_cnt <= '0;
    else if (r_state != S_BUS) r_tmo_cnt <= '0;
    else                       r_tmo_cnt <= r_tmo_cnt + 16'd1;
  end

  // Ready in the terminal cycle takes precedence over the abort.
  assign w_timeout = (r_state == S_BUS) && r_iomem_valid && !iomem_ready &&
                     (r_tmo_cnt == TMO_LAST);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TMO_LAST;
  assign w_timeout    = 1'b0;
`endif

  // Read-data byte that follows the one currently on out_data.
  always_comb begin
    w_next_byte = r_rdata[7:0];
    case (r_cnt)
      2'd0:    w_next_byte = r_rdata[23:16];
      2'd1:    w_next_byte = r_rdata[15:8];
      default: w_next_byte = r_rdata[7:0];
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_in_fire && w_is_op) w_state_next = S_ADDR;
      S_ADDR: if (w_in_fire && (r_cnt == 2'd3)) w_state_next = r_write ? S_DATA : S_BUS;
      S_DATA: if (w_in_fire && (r_cnt == 2'd3)) w_state_next = S_BUS;
      S_BUS:  if (w_bus_done || w_timeout) w_state_next = S_RESP;
      S_RESP: if (w_out_fire && w_resp_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // busy is registered from the next state so it tracks r_state exactly.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_busy <= 1'b0;
    else         r_busy <= (w_state_next != S_IDLE);
  end

  // Datapath: command shifting, bus request, response byte sequencing.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt         <= '0;
      r_write       <= 1'b0;
      r_nak         <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_iomem_valid <= 1'b0;
      r_iomem_wstrb <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_fire && w_is_op) begin
            r_write <= (in_data == OP_WRITE);
            r_cnt   <= '0;
          end
        end
        S_ADDR: begin
          if (w_in_fire) begin
            r_addr <= {r_addr[23:0], in_data};
            r_cnt  <= r_cnt + 2'd1;
            if ((r_cnt == 2'd3) && !r_write) begin
              r_iomem_valid <= 1'b1;
              r_iomem_wstrb <= 4'b0000;
            end
          end
        end
        S_DATA: begin
          if (w_in_fire) begin
            r_wdata <= {r_wdata[23:0], in_data};
            r_cnt   <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_iomem_valid <= 1'b1;
              r_iomem_wstrb <= 4'b1111;
            end
          end
        end
        S_BUS: begin
          if (w_bus_done) begin
            r_iomem_valid <= 1'b0;
            r_iomem_wstrb <= 4'b0000;
            r_rdata       <= iomem_rdata[23:0];
            r_nak         <= 1'b0;
            r_cnt         <= '0;
            r_out_valid   <= 1'b1;
            r_out_data    <= r_write ? RSP_ACK : iomem_rdata[31:24];
          end else if (w_timeout) begin
            r_iomem_valid <= 1'b0;
            r_iomem_wstrb <= 4'b0000;
            r_nak         <= 1'b1;
            r_cnt         <= '0;
            r_out_valid   <= 1'b1;
            r_out_data    <= RSP_NAK;
          end
        end
        S_RESP: begin
          if (w_out_fire) begin
            if (w_resp_last) begin
              r_out_valid <= 1'b0;
            end else begin
              r_cnt      <= r_cnt + 2'd1;
              r_out_data <= w_next_byte;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_uart_bridge.sv
// Directed bench for iomem_uart_bridge: a vector table of complete
// transactions plus hand-written sequences for garbage bytes, queued
// commands, timeout behaviour and reset in mid-operation.
module tb_iomem_uart_bridge;

  localparam int TMO = 8;
  localparam int WAIT_MAX = 50;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        busy;
  logic [2:0]  dbg_state;

  iomem_uart_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  logic [7:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    int          stall;
    int          n_resp;
    logic [31:0] resp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: present one command byte and hold it until accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    if (n >= WAIT_MAX) check("in_ready_wait", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_fields(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
    if (wr) for (int i = 3; i >= 0; i--) send_byte(wdata[8*i +: 8]);
  endtask

  task automatic send_packet(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    send_byte(wr ? 8'h57 : 8'h52);
    send_fields(wr, addr, wdata);
  endtask

  // Responder: checks the request, waits, then pulses ready for one cycle.
  task automatic bus_serve(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int delay);
    check("iomem_valid_latency", 32'(iomem_valid), 32'd1);
    check("iomem_addr", iomem_addr, addr);
    check("iomem_wstrb", 32'(iomem_wstrb), wr ? 32'hF : 32'h0);
    if (wr) check("iomem_wdata", iomem_wdata, wdata);
    check("in_ready_bus", 32'(in_ready), 32'd0);
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      check("iomem_valid_hold", 32'(iomem_valid), 32'd1);
      check("iomem_addr_hold", iomem_addr, addr);
    end
    iomem_ready = 1'b1;
    iomem_rdata = rdata;
    @(negedge clk);
    iomem_ready = 1'b0;
    iomem_rdata = $urandom;
    check("iomem_valid_drop", 32'(iomem_valid), 32'd0);
    check("iomem_wstrb_drop", 32'(iomem_wstrb), 32'd0);
    check("out_valid_latency", 32'(out_valid), 32'd1);
  endtask

  // Scoreboard sink: drains exp_q, stalling `stall` cycles before each byte.
  task automatic recv_resp(input int stall);
    int n;
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (stall > 0) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          check("stall_out_valid", 32'(out_valid), 32'd1);
          check("stall_out_data", 32'(out_data), 32'(e));
          @(negedge clk);
        end
      end
      out_ready = 1'b1;
      n = 0;
      while (!out_valid && n < WAIT_MAX) begin
        @(negedge clk);
        n++;
      end
      check("in_ready_resp", 32'(in_ready), 32'd0);
      check("resp_byte", 32'(out_data), 32'(e));
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("out_valid_end", 32'(out_valid), 32'd0);
    check("in_ready_end", 32'(in_ready), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    for (int i = v.n_resp - 1; i >= 0; i--) exp_q.push_back(v.resp[8*i +: 8]);
    send_packet(v.wr, v.addr, v.wdata);
    bus_serve(v.wr, v.addr, v.wdata, v.rdata, v.delay);
    recv_resp(v.stall);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    resetn      = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    out_ready   = 1'b0;
    iomem_ready = 1'b0;
    iomem_rdata = 32'h0;

    //        wr    addr          wdata         rdata         dly stl n  resp
    vecs[0] = '{1'b1, 32'h0300_0000, 32'h0000_00A5, 32'hFFFF_FFFF, 2, 0, 1, 32'h0000_0006};
    vecs[1] = '{1'b0, 32'h0400_0000, 32'h0000_0000, 32'h1234_5678, 0, 0, 4, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 32'hA5C3_0F81, 3, 2, 4, 32'hA5C3_0F81};
    vecs[3] = '{1'b1, 32'h8000_0004, 32'hFFFF_0000, 32'h5555_5555, 0, 3, 1, 32'h0000_0006};
    vecs[4] = '{1'b0, 32'h0500_0000, 32'h0000_0000, 32'h00FF_00FF, 1, 5, 4, 32'h00FF_00FF};
    vecs[5] = '{1'b1, 32'h0000_0000, 32'h1234_5678, 32'h8765_4321, 5, 1, 1, 32'h0000_0006};

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_iomem_valid", 32'(iomem_valid), 32'd0);
    check("rst_iomem_wstrb", 32'(iomem_wstrb), 32'd0);
    check("rst_iomem_addr", iomem_addr, 32'd0);
    check("rst_iomem_wdata", iomem_wdata, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    resetn = 1'b1;
    @(negedge clk);

    // Stray ready while no request is outstanding.
    iomem_ready = 1'b1;
    iomem_rdata = 32'hCAFE_BABE;
    @(negedge clk);
    iomem_ready = 1'b0;
    @(negedge clk);
    check("stray_ready_out_valid", 32'(out_valid), 32'd0);
    check("stray_ready_state", 32'(dbg_state), 32'd0);

    // Table-driven transactions.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Garbage bytes, then a read with a write command queued behind it.
    send_byte(8'h00);
    check("garbage0_busy", 32'(busy), 32'd0);
    send_byte(8'hFF);
    check("garbage1_state", 32'(dbg_state), 32'd0);
    check("garbage_no_resp", 32'(out_valid), 32'd0);
    exp_q.push_back(8'hCA); exp_q.push_back(8'hFE);
    exp_q.push_back(8'hF0); exp_q.push_back(8'h0D);
    send_packet(1'b0, 32'h0500_0000, 32'h0);
    in_valid = 1'b1;
    in_data  = 8'h57;
    bus_serve(1'b0, 32'h0500_0000, 32'h0, 32'hCAFE_F00D, 1);
    check("queued_state_resp", 32'(dbg_state), 32'd4);
    recv_resp(0);
    check("queued_not_consumed", 32'(dbg_state), 32'd0);
    send_byte(8'h57);
    check("queued_opcode_taken", 32'(dbg_state), 32'd1);
    send_fields(1'b1, 32'h0000_0010, 32'h0000_0001);
    exp_q.push_back(8'h06);
    bus_serve(1'b1, 32'h0000_0010, 32'h0000_0001, 32'h0, 0);
    recv_resp(0);

    // Unanswered read.
    send_packet(1'b0, 32'h0600_0000, 32'h0);
`ifdef IOMEM_TIMEOUT_EN
    for (int i = 0; i < TMO; i++) begin
      check("tmo_valid_high", 32'(iomem_valid), 32'd1);
      @(negedge clk);
    end
    check("tmo_valid_low", 32'(iomem_valid), 32'd0);
    check("tmo_out_valid", 32'(out_valid), 32'd1);
    exp_q.push_back(8'h15);
    recv_resp(0);
`else
    for (int i = 0; i < 20; i++) begin
      check("no_tmo_valid_high", 32'(iomem_valid), 32'd1);
      @(negedge clk);
    end
    exp_q.push_back(8'h0B); exp_q.push_back(8'hAD);
    exp_q.push_back(8'hF0); exp_q.push_back(8'h0D);
    bus_serve(1'b0, 32'h0600_0000, 32'h0, 32'h0BAD_F00D, 0);
    recv_resp(0);
`endif

    // Reset while a bus request is outstanding.
    send_packet(1'b0, 32'h0700_0000, 32'h0);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("rst_bus_iomem_valid", 32'(iomem_valid), 32'd0);
    check("rst_bus_busy", 32'(busy), 32'd0);
    check("rst_bus_in_ready", 32'(in_ready), 32'd1);
    check("rst_bus_addr", iomem_addr, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Reset during the second response byte.
    send_packet(1'b0, 32'h0800_0000, 32'h0);
    bus_serve(1'b0, 32'h0800_0000, 32'h0, 32'h1122_3344, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("second_byte", 32'(out_data), 32'h22);
    #2 resetn = 1'b0;
    #1;
    check("rst_resp_out_valid", 32'(out_valid), 32'd0);
    check("rst_resp_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Fresh packet after reset.
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
